// File: rtl/ps2_kbd_ctrl.sv
// Host-side PS/2 keyboard receiver: sync + glitch filter, frame FSM, scancode FIFO.
// Optional break-code folding (F0 prefix -> key_release flag) under PS2_BREAK_DECODE_EN.
module ps2_kbd_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned TIMEOUT    = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] data_out,
    output logic       parity_err,
    output logic       overflow
`ifdef PS2_BREAK_DECODE_EN
    ,
    output logic       key_release
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILT_LEN);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
`ifdef PS2_BREAK_DECODE_EN
    localparam int unsigned EW = 9;
`else
    localparam int unsigned EW = 8;
`endif

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_d, filt_prev_q;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_e        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          push_q, push_d;
    logic [EW-1:0] push_data_q, push_data_d;
    logic          perr_q, perr_d;
    logic          ovf_q, ovf_d;
    logic          brk_q, brk_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic fall, frame_ok, pop, full, wr;

    assign fall     = filt_prev_q & ~filt_q;
    assign frame_ok = dat_s2_q & (^shreg_q ^ par_q);

    // Filtered clock flips only after FILT_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        wd_d        = wd_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        perr_d      = 1'b0;
        brk_d       = brk_q;
        if (fall) begin
            wd_d = '0;
            case (state_q)
                StIdle: begin
                    if (!dat_s2_q) begin
                        state_d  = StData;
                        bitcnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d = {dat_s2_q, shreg_q[7:1]};
                    if (bitcnt_q == 3'd7) begin
                        state_d = StParity;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                StParity: begin
                    par_d   = dat_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (frame_ok) begin
`ifdef PS2_BREAK_DECODE_EN
                        if (shreg_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            push_d      = 1'b1;
                            push_data_d = {brk_q, shreg_q};
                            brk_d       = 1'b0;
                        end
`else
                        push_d      = 1'b1;
                        push_data_d = shreg_q;
`endif
                    end else begin
                        perr_d = 1'b1;
                        brk_d  = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (wd_q == WW'(TIMEOUT - 1)) begin
                state_d = StIdle;
                wd_d    = '0;
                brk_d   = 1'b0;
            end else begin
                wd_d = wd_q + WW'(1);
            end
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        pop      = sel & (cnt_q != '0);
        full     = (cnt_q == CW'(FIFO_DEPTH));
        wr       = push_q & (~full | pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = push_data_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
        if (pop) begin
            ovf_d = 1'b0;
        end else if (push_q && full) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= StIdle;
            bitcnt_q    <= 3'd0;
            shreg_q     <= 8'h00;
            par_q       <= 1'b0;
            wd_q        <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            perr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            brk_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            wd_q        <= wd_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            perr_q      <= perr_d;
            ovf_q       <= ovf_d;
            brk_q       <= brk_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            mem_q       <= mem_d;
        end
    end

    assign data_out   = (cnt_q != '0) ? {1'b1, mem_q[rd_ptr_q][7:0]} : 9'h000;
    assign parity_err = perr_q;
    assign overflow   = ovf_q;
`ifdef PS2_BREAK_DECODE_EN
    assign key_release = (cnt_q != '0) & mem_q[rd_ptr_q][8];
`endif

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: transaction-level queue model checked every quiet cycle,
// plus literal expectations for the documented scenarios.
module tb_ps2_kbd_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sel = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] data_out;
    logic       parity_err;
    logic       overflow;
`ifdef PS2_BREAK_DECODE_EN
    logic       key_release;
`endif

    ps2_kbd_ctrl #(
        .FIFO_DEPTH(DEPTH),
        .FILT_LEN  (4),
        .TIMEOUT   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_out  (data_out),
        .parity_err(parity_err),
        .overflow  (overflow)
`ifdef PS2_BREAK_DECODE_EN
        ,
        .key_release(key_release)
`endif
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    bit         quiet = 1'b0;
    logic [8:0] exp_q[$];   // {release, byte}
    bit         exp_ovf = 1'b0;
    bit         brk_pend = 1'b0;
    int         exp_perr = 0;
    int         perr_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_dout();
        if (exp_q.size() > 0) return {1'b1, exp_q[0][7:0]};
        return 9'h000;
    endfunction

    always @(negedge clk) begin
        if (quiet) begin
            check("model_data_out", {23'd0, data_out}, {23'd0, exp_dout()});
            check("model_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
`ifdef PS2_BREAK_DECODE_EN
            check("model_key_release", {31'd0, key_release},
                  {31'd0, (exp_q.size() > 0) ? exp_q[0][8] : 1'b0});
`endif
        end
    end

    always @(negedge clk) begin
        if (rst && parity_err) perr_seen++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: optional pop at the write edge, then apply the frame's outcome.
    task automatic model_frame(input logic [7:0] b, input bit ok, input bit popw);
        logic [8:0] entry;
        if (popw && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        if (!ok) begin
            exp_perr++;
            brk_pend = 1'b0;
            return;
        end
`ifdef PS2_BREAK_DECODE_EN
        if (b == 8'hF0) begin
            brk_pend = 1'b1;
            return;
        end
        entry    = {brk_pend, b};
        brk_pend = 1'b0;
`else
        entry = {1'b0, b};
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(entry);
        else exp_ovf = 1'b1;
    endtask

    // Each bit: data set while clk high, 20 cycles high, 20 cycles low.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch,
                             input bit lat, input bit popw);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(8);
            if (glitch) ps2_clk = 1'b0;
            tick(2);
            ps2_clk = 1'b1;
            tick(10);
            ps2_clk = 1'b0;
            if (i == 10 && (lat || popw)) begin
                tick(7);
                if (lat) check("latency_before", {31'd0, data_out[8]}, 32'd0);
                if (popw) sel = 1'b1;
                tick(1);
                sel = 1'b0;
                if (lat) check("latency_after", {31'd0, data_out[8]}, 32'd1);
                tick(12);
            end else begin
                tick(20);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit par_flip, input bit glitch,
                         input bit lat, input bit popw);
        logic        p;
        logic [10:0] bits;
        p    = (~^b) ^ par_flip;
        bits = {1'b1, p, b, 1'b0};
        quiet = 1'b0;
        send_bits(bits, 11, glitch, lat, popw);
        tick(20);
        model_frame(b, (^b ^ p) == 1'b1, popw);
        quiet = 1'b1;
        tick(4);
    endtask

    task automatic read_pop();
        quiet = 1'b0;
        sel = 1'b1;
        tick(1);
        sel = 1'b0;
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        quiet = 1'b1;
        tick(2);
    endtask

    task automatic read_chk(input string name, input logic [8:0] lit);
        check(name, {23'd0, data_out}, {23'd0, lit});
        read_pop();
    endtask

    initial begin
        rst = 1'b0;
        tick(3);
        check("reset_data_out", {23'd0, data_out}, 32'h000);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b1;
        quiet = 1'b1;
        tick(10);

        // 1: basic frame with exact latency, then read
        frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);
        read_chk("t1_data", 9'h11C);
        check("t1_empty", {23'd0, data_out}, 32'h000);

        // 2: bad parity
        frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_data", {23'd0, data_out}, 32'h000);
        check("t2_overflow", {31'd0, overflow}, 32'd0);
        check("t2_perr_pulses", perr_seen, 32'd1);

        // 3: overflow then drain
        for (int k = 1; k <= 5; k++) frame(8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_overflow_set", {31'd0, overflow}, 32'd1);
        read_chk("t3_rd1", 9'h101);
        check("t3_overflow_clr", {31'd0, overflow}, 32'd0);
        read_chk("t3_rd2", 9'h102);
        read_chk("t3_rd3", 9'h103);
        read_chk("t3_rd4", 9'h104);
        check("t3_empty", {23'd0, data_out}, 32'h000);

        // 4: partial frame abandoned by watchdog
        quiet = 1'b0;
        send_bits({1'b1, 1'b0, 8'h55, 1'b0}, 4, 1'b0, 1'b0, 1'b0);
        tick(TMO + 10);
        brk_pend = 1'b0;
        quiet = 1'b1;
        frame(8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_data", {23'd0, data_out}, 32'h132);
        check("t4_perr_pulses", perr_seen, 32'd1);
        read_pop();

        // 5: short clock glitches inside a frame
        frame(8'h2A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5_data", {23'd0, data_out}, 32'h12A);
        read_pop();

        // 6: break prefix
        frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PS2_BREAK_DECODE_EN
        check("t6_release", {31'd0, key_release}, 32'd1);
        read_chk("t6_rd1", 9'h11C);
`else
        read_chk("t6_rd1", 9'h1F0);
        read_chk("t6_rd2", 9'h11C);
`endif
        check("t6_empty", {23'd0, data_out}, 32'h000);

        // 7: push and pop on the same edge while full, then sel on empty at push
        for (int k = 0; k < 4; k++) frame(8'h10 + 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        frame(8'h14, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t7_no_overflow", {31'd0, overflow}, 32'd0);
        read_chk("t7_rd1", 9'h111);
        read_chk("t7_rd2", 9'h112);
        read_chk("t7_rd3", 9'h113);
        read_chk("t7_rd4", 9'h114);
        frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        read_chk("t7_sel_empty", 9'h15A);

        // 8: reset in the middle of a frame
        quiet = 1'b0;
        send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 3, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        exp_q.delete();
        exp_ovf  = 1'b0;
        brk_pend = 1'b0;
        quiet = 1'b1;
        tick(5);
        frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t8_data", {23'd0, data_out}, 32'h11C);
        read_pop();

        check("final_perr_pulses", perr_seen, exp_perr);
        quiet = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
